// File: rtl/period_meas.sv
// ---------------------------------------------------------------------------
// period_meas
//
// Measures the interval, in clk cycles, between consecutive rising edges of
// an asynchronous input and presents it to downstream capture logic as a
// registered period value with a one-cycle capture strobe.
//
// Ports:
//   clk      system clock, all logic on its rising edge
//   rst      asynchronous active-high reset
//   en       measurement enable; low returns the block to IDLE
//   sig_in   asynchronous signal being measured
//   period   last measured period in clk cycles (saturates at 2^WIDTH-1)
//   capture  one-cycle strobe, high in the cycle period is updated
//   ovf      high while the current interval has saturated the counter
//   valid    sticky, high once any capture has occurred since reset
//
// Parameters:
//   WIDTH        width of period and of the interval counter
//   SYNC_STAGES  synchronizer depth on sig_in (must be at least 2)
// ---------------------------------------------------------------------------
module period_meas #(
    parameter int WIDTH       = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             capture,
    output logic             ovf,
    output logic             valid
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOW,
        WAIT_RISE,
        MEAS
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   sig_s;
    logic                   sig_d;
    logic                   rise;
    logic                   sync_ok;

    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] period_n;
    logic             capture_n;
    logic             ovf_n;
    logic             valid_n;

    // Synchronizer chain and edge-detect delay. fill_q tracks how many real
    // samples have reached the end of the chain since reset, because the
    // reset zeros in sync_q are not a genuine low level of sig_in: a high
    // input held through reset release must not look like a low followed
    // by a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sig_d  <= sig_s;
        end
    end

    assign sig_s   = sync_q[SYNC_STAGES-1];
    assign rise    = sig_s & ~sig_d;
    assign sync_ok = fill_q[SYNC_STAGES-1];

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= '0;
            capture <= 1'b0;
            ovf     <= 1'b0;
            valid   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            period  <= period_n;
            capture <= capture_n;
            ovf     <= ovf_n;
            valid   <= valid_n;
        end
    end

    // Next-state logic. A rising edge in MEAS closes the current interval
    // and opens the next one in the same cycle, so cnt restarts at 1 rather
    // than 0. en low has priority over everything, including a coincident
    // edge, and leaves period and valid untouched.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        period_n  = period;
        capture_n = 1'b0;
        ovf_n     = ovf;
        valid_n   = valid;

        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
            ovf_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                    state_n = WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (sync_ok && !sig_s) begin
                        state_n = WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        cnt_n   = CNT_ONE;
                        state_n = MEAS;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_n  = cnt;
                        capture_n = 1'b1;
                        valid_n   = 1'b1;
                        ovf_n     = 1'b0;
                        cnt_n     = CNT_ONE;
                    end else if (cnt != CNT_MAX) begin
                        cnt_n = cnt + CNT_ONE;
                        if (cnt_n == CNT_MAX) begin
                            ovf_n = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule
